// File: rtl/uart_tx_serializer_if.sv
// Byte-in / serial-out handshake bundle of the UART transmit stage; the master drives tick, request and data.
// Outputs tx/busy/done come from registers on the serializer side, so nothing in here is combinational.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  baud_tick;
    logic                  transmit;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  tx;
    logic                  busy;
    logic                  done;

    modport master (
        output baud_tick,
        output transmit,
        output data_in,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  baud_tick,
        input  transmit,
        input  data_in,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start, DATA_WIDTH bits LSB-first, optional even parity (UART_TX_PARITY_EN), stop; one bit per baud tick.
// Registered outputs; a frame starts on the first tick after accept, and requests are ignored while busy.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    uart_tx_serializer_if.slave   bus
);

    localparam logic [BIT_CNT_W-1:0] LAST_IDX = BIT_CNT_W'(DATA_WIDTH - 1);

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
            $error("uart_tx_serializer: DATA_WIDTH must be within 5..9");
        end
        if ((2 ** BIT_CNT_W) <= DATA_WIDTH) begin : g_bad_cnt
            $error("uart_tx_serializer: BIT_CNT_W too narrow for DATA_WIDTH");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BIT_CNT_W-1:0]  r_idx;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [BIT_CNT_W-1:0]  w_idx;
    logic                  w_tx;
    logic                  w_busy;
    logic                  w_done;

`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
    logic                  w_parity;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_shift <= w_shift;
            r_idx   <= w_idx;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity;
        end
    end
`endif

    // Every state except IDLE advances only on a baud tick; otherwise all registers hold.
    always_comb begin
        w_state = r_state;
        w_shift = r_shift;
        w_idx   = r_idx;
        w_tx    = r_tx;
        w_busy  = r_busy;
        w_done  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                if (bus.transmit) begin
                    w_shift = bus.data_in;
                    w_idx   = '0;
                    w_busy  = 1'b1;
                    w_state = S_ALIGN;
`ifdef UART_TX_PARITY_EN
                    w_parity = ^bus.data_in;
`endif
                end
            end
            S_ALIGN: begin
                if (bus.baud_tick) begin
                    w_tx    = 1'b0;
                    w_state = S_START;
                end
            end
            S_START: begin
                if (bus.baud_tick) begin
                    w_tx    = r_shift[0];
                    w_shift = {1'b0, r_shift[DATA_WIDTH-1:1]};
                    w_idx   = '0;
                    w_state = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.baud_tick) begin
                    if (r_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        w_tx    = r_parity;
                        w_state = S_PARITY;
`else
                        w_tx    = 1'b1;
                        w_state = S_STOP;
`endif
                    end else begin
                        w_tx    = r_shift[0];
                        w_shift = {1'b0, r_shift[DATA_WIDTH-1:1]};
                        w_idx   = r_idx + BIT_CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bus.baud_tick) begin
                    w_tx    = 1'b1;
                    w_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bus.baud_tick) begin
                    w_tx    = 1'b1;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_tx    = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            assert (r_idx <= LAST_IDX)
                else $error("uart_tx_serializer: bit index past last data bit");
            assert (!(r_done && r_busy))
                else $error("uart_tx_serializer: done raised while still busy");
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: fixed vector table, directed corner sequences, then random traffic
// checked every cycle against a frame-as-bit-list reference model.
module tb_uart_tx_serializer;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_tx_serializer_if #(.DATA_WIDTH(DW)) bif ();

    uart_tx_serializer #(.DATA_WIDTH(DW), .BIT_CNT_W(4)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bif)
    );

    always #5 clk = ~clk;

    // Reference: a frame is a list of line levels; a tick moves one entry along it.
    logic m_tx = 1'b1;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    int   m_pos = -1;
    logic m_frame [0:15];

    always @(posedge clk) begin
        m_done = 1'b0;
        if (!rst_n) begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            m_tx = 1'b1;
            if (bif.transmit) begin
                m_busy = 1'b1;
                m_pos  = -1;
                m_frame[0] = 1'b0;
                for (int i = 0; i < DW; i++) m_frame[1+i] = bif.data_in[i];
`ifdef UART_TX_PARITY_EN
                m_frame[DW+1] = ^bif.data_in;
`endif
                m_frame[NBITS-1] = 1'b1;
            end
        end else if (bif.baud_tick) begin
            if (m_pos == NBITS - 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_tx   = 1'b1;
            end else begin
                m_pos = m_pos + 1;
                m_tx  = m_frame[m_pos];
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic t, input logic x, input logic [DW-1:0] d);
        @(negedge clk);
        rst_n         = r;
        bif.baud_tick = t;
        bif.transmit  = x;
        bif.data_in   = d;
        @(posedge clk);
        #1;
        chk("model_tx", int'(bif.tx), int'(m_tx));
        chk("model_busy", int'(bif.busy), int'(m_busy));
        chk("model_done", int'(bif.done), int'(m_done));
    endtask

    typedef struct {
        logic          rst_n;
        logic          tick;
        logic          trans;
        logic [DW-1:0] data;
        logic          e_tx;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic t, logic x, logic [DW-1:0] d,
                                logic etx, logic eb, logic ed);
        vec_t v;
        v.rst_n = r; v.tick = t; v.trans = x; v.data = d;
        v.e_tx = etx; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    initial begin
        logic exp_q[$];
        logic rec[$];
        int   dones, seen, post, low, zeros, hit;
        logic t;

        bif.baud_tick = 1'b0;
        bif.transmit  = 1'b0;
        bif.data_in   = '0;

        // 0xA5 with the tick tied high; the accept-cycle tick is not counted, a mid-frame 0x3C is ignored.
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 8'hA5, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 8'h3C, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 1, 1, 0));
`ifdef UART_TX_PARITY_EN
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 0));
`endif
        tbl.push_back(mk(1, 1, 0, 8'h00, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 1, 0, 0));

        drive(0, 0, 0, '0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].tick, tbl[i].trans, tbl[i].data);
            chk($sformatf("vec%0d_tx", i), int'(bif.tx), int'(tbl[i].e_tx));
            chk($sformatf("vec%0d_busy", i), int'(bif.busy), int'(tbl[i].e_busy));
            chk($sformatf("vec%0d_done", i), int'(bif.done), int'(tbl[i].e_done));
        end

        // Basic frame, tick every 4 clocks, with a second request mid-frame.
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(1'b0);
`endif
        exp_q.push_back(1'b1);
        dones = 0; seen = 0; post = 0;
        for (int i = 0; i < 200 && post < 8; i++) begin
            t = (i % 4 == 3);
            drive(1, t, (i == 0) || (i == 10), (i == 10) ? 8'h3C : 8'hA5);
            if (bif.done) begin
                dones++;
                chk("basic_done_busy", int'(bif.busy), 0);
                seen = 1;
            end else if (!seen) begin
                chk("basic_busy", int'(bif.busy), 1);
                if (t) rec.push_back(bif.tx);
            end
            if (seen) post++;
        end
        chk("basic_seen_done", seen, 1);
        chk("basic_done_count", dones, 1);
        chk("basic_nbits", rec.size(), NBITS);
        for (int i = 0; i < rec.size() && i < exp_q.size(); i++)
            chk($sformatf("basic_bit%0d", i), int'(rec[i]), int'(exp_q[i]));

        // Back-to-back frames of 0x55 with transmit held high.
        dones = 0; low = 0;
        for (int i = 0; i < 400 && dones < 3; i++) begin
            drive(1, i % 2 == 1, 1, 8'h55);
            if (bif.done) dones++;
            if (!bif.busy) low++;
            else if (low > 0) begin
                chk("b2b_gap", low, 1);
                low = 0;
            end
        end
        chk("b2b_done_count", dones, 3);
        for (int i = 0; i < 40; i++) drive(1, 1, 0, 8'h00);
        chk("b2b_idle", int'(bif.busy), 0);

        // Continuous tick with 0xFF: one low clock of start, done 11 (or 12) clocks after accept.
        drive(1, 1, 1, 8'hFF);
        zeros = 0; hit = 0;
        for (int k = 1; k <= 30 && !hit; k++) begin
            drive(1, 1, 0, 8'h00);
            if (!bif.tx) zeros++;
            if (bif.done) begin
                chk("cont_done_at", k, NBITS + 1);
                hit = 1;
            end
        end
        chk("cont_done_seen", hit, 1);
`ifdef UART_TX_PARITY_EN
        chk("cont_low_clocks", zeros, 2);
`else
        chk("cont_low_clocks", zeros, 1);
`endif

        // Reset while data bit 3 is on the line.
        drive(1, 1, 1, 8'hA5);
        for (int k = 0; k < 5; k++) drive(1, 1, 0, 8'h00);
        chk("rst_pre_busy", int'(bif.busy), 1);
        chk("rst_pre_tx_bit3", int'(bif.tx), 0);
        drive(0, 1, 0, 8'h00);
        chk("rst_tx", int'(bif.tx), 1);
        chk("rst_busy", int'(bif.busy), 0);
        chk("rst_done", int'(bif.done), 0);
        hit = 0;
        for (int k = 0; k < 50; k++) begin
            drive(1, 1'($urandom_range(0, 1)), 0, 8'($urandom));
            if (!bif.tx || bif.busy) hit++;
        end
        chk("rst_quiet_50", hit, 0);

        // Random traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            drive(1'($urandom_range(0, 499) != 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 3) == 0),
                  8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Serial transmit stage of the UART. Sits directly downstream of the baud-rate tick counter and consumes its one-cycle tick pulse.
- Accepts a parallel byte with a start strobe and shifts out an 8N1 frame on Tx: start bit, DATA_WIDTH data bits LSB-first, an optional parity bit, then a stop bit.
- Each bit lasts exactly one tick interval. Busy and Done flags feed the host/control FSM.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (valid range 5..9).
- BIT_CNT_W, 4, width of the internal bit index. Must satisfy 2^BIT_CNT_W > DATA_WIDTH.

Ports:
- Clk, input, 1, system clock; all logic on the rising edge.
- Reset, input, 1, synchronous active-low reset, sampled on the rising Clk edge.
- Baud_Tick, input, 1, one-cycle pulse from the baud counter; marks bit boundaries.
- Transmit, input, 1, start request; level-sampled in IDLE only.
- Data_In, input, DATA_WIDTH, byte to send; captured on the accept cycle only.
- Tx, output, 1, serial line; idle high.
- Busy, output, 1, high from the accept cycle +1 until the frame completes.
- Done, output, 1, one-cycle pulse at frame completion.

Behaviour:
- Reset (Reset==0 at a Clk edge): state=IDLE, Tx=1, Busy=0, Done=0, shift register=0, bit index=0. Reset overrides everything, including a frame in progress. Tx returns to 1 on the same edge; there is no partial stop bit.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, ALIGN, START, DATA, PARITY (macro only), STOP.
- IDLE: Tx=1, Busy=0. If Transmit==1: latch Data_In into the shift register, clear the bit index, Busy<=1, go to ALIGN.
- ALIGN: Tx=1. Wait for the next Baud_Tick. A tick coincident with the accept cycle is not counted. On tick: Tx<=0, go to START.
- START: on tick: Tx<=shift[0], shift right by 1, index<=0, go to DATA.
- DATA: on tick:
  - If index==DATA_WIDTH-1, go to PARITY (macro) or STOP with Tx<=1.
  - Otherwise Tx<=shift[0], shift right, index++.
- STOP: Tx=1. On tick: Done<=1 for one cycle, Busy<=0, go to IDLE.
- Every transition out of ALIGN/START/DATA/PARITY/STOP occurs only on a cycle with Baud_Tick==1. Without a tick, the state and Tx hold.
- Bit timing: each of start, data, parity and stop is held for exactly one tick-to-tick interval.
- Frame length from the first tick after accept to Done = (DATA_WIDTH+2[+1 parity]) tick intervals.
- Transmit while Busy is ignored. Data_In changes after accept have no effect on the current frame.
- Back-to-back: IDLE is re-entered on the Done cycle. If Transmit==1 on the next cycle, a new frame is accepted, giving an inter-frame gap of one stop bit plus alignment.
- Baud_Tick held constantly high: advances one bit per Clk. Legal; used for fast simulation.
- The bit index never exceeds DATA_WIDTH-1. No wrap is permitted.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP.
  - Tx = even parity = XOR of all latched data bits. The parity is computed at accept from Data_In, not from the shifted register.
  - Frame is DATA_WIDTH+3 bits.
- Undefined: no PARITY state and no parity register; DATA goes directly to STOP. Frame is DATA_WIDTH+2 bits.

Test Plan:
- Basic frame: Baud_Tick every 4 Clk; Transmit=1 for 1 cycle with Data_In=0xA5.
  - Tx per interval: 1(align), then 0,1,0,1,0,0,1,0,1,1.
  - Busy=1 throughout; Done is a single pulse on the stop-end tick, with Busy=0 on that same cycle.
- Parity (macro defined): 0xA5 inserts parity 0 before stop; 0x07 inserts parity 1. Frame is 11 bit-intervals.
- Ignore while busy: second Transmit pulse with Data_In=0x3C mid-frame of 0xA5 → the line carries only 0xA5; a single Done.
- Back-to-back: Transmit held high, Data_In=0x55 → consecutive frames 0,1,0,1,0,1,0,1,0,1 each; one Done per frame; Busy low for exactly 1 cycle between frames.
- Reset mid-frame: Reset=0 during DATA bit 3 → next edge Tx=1, Busy=0, Done=0. After release with no Transmit, Tx stays 1 for 50 cycles.
- Continuous tick: Baud_Tick tied 1, Data_In=0xFF → start low for exactly 1 Clk, then 8 high data bits, then stop; Done 11 Clk after accept (ALIGN 1 + 10 bits).
